vram_write_scheduler: RTL and testbench

Arbiter and scheduler for the single-port 3-bit video memory shared by the MiniAlu store path and the VGA scanout reader. It buffers CPU pixel writes in a small FIFO, gives scanout reads strict priority, and drains queued writes into memory during cycles with no read request. It sits between the CPU core, the VGA timing/fetch logic and the video RAM instance, and is the only block that drives the RAM address, write enable and data-in.

---
 rtl/vram_write_scheduler_if.sv | 33 +++
 rtl/vram_write_scheduler.sv | 155 +++++++++++++++
 tb/tb_vram_write_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vram_write_scheduler_if.sv
// Bus bundle between the video RAM scheduler and its three neighbours: the CPU
// store path, the VGA scanout fetcher and the single-port video RAM.
interface vram_write_scheduler_if #(
  parameter int AW = 24,
  parameter int DW = 3
);
  // CPU write: a push happens on any rising edge where iWriteReq=1 and oFull=0;
  // the CPU holds or drops the request while oFull=1. Scanout reads have no
  // back-pressure: a sampled iReadReq is either served (oReadValid two edges
  // later) or dropped (oReadMiss pulse).
  logic          iWriteReq;
  logic [AW-1:0] iWriteAddress;
  logic [DW-1:0] iWriteData;
  logic          oFull;
  logic          iReadReq;
  logic [AW-1:0] iReadAddress;
  logic          oReadValid;
  logic          oReadMiss;
  logic [AW-1:0] oRamAddress;
  logic          oRamWriteEnable;
  logic [DW-1:0] oRamDataIn;
  logic [DW-1:0] iRamDataOut;

  modport slave (
    input  iWriteReq, iWriteAddress, iWriteData, iReadReq, iReadAddress, iRamDataOut,
    output oFull, oReadValid, oReadMiss, oRamAddress, oRamWriteEnable, oRamDataIn
  );

  modport master (
    output iWriteReq, iWriteAddress, iWriteData, iReadReq, iReadAddress, iRamDataOut,
    input  oFull, oReadValid, oReadMiss, oRamAddress, oRamWriteEnable, oRamDataIn
  );
endinterface

// File: rtl/vram_write_scheduler.sv
// Video RAM port scheduler: buffers CPU pixel writes, gives scanout reads priority.
// Optional macro VRAM_STARVE_GUARD_EN enables the forced-write starvation guard.
module vram_write_scheduler #(
  parameter int DEPTH     = 8,
  parameter int AW        = 24,
  parameter int DW        = 3,
  parameter int MAX_STALL = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1,
  localparam int SW = $clog2(MAX_STALL + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  vram_write_scheduler_if.slave bus,
  output logic [1:0]           dbg_state,
  output logic [CW-1:0]        dbg_count,
  output logic [SW-1:0]        dbg_stall
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FORCE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d;
  logic          rv_q, rv_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] din_q, din_d;
  logic          push, pop;

  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];

`ifdef VRAM_STARVE_GUARD_EN
  logic [SW-1:0] stall_q, stall_d;
  logic          miss_q, miss_d;
`endif

  always_comb begin
    push     = bus.iWriteReq && !full_q;
    pop      = 1'b0;
    state_d  = ST_IDLE;
    addr_d   = addr_q;
    we_d     = 1'b0;
    din_d    = din_q;
`ifdef VRAM_STARVE_GUARD_EN
    miss_d   = 1'b0;
    if ((stall_q == SW'(MAX_STALL)) && (count_q != '0)) begin
      state_d = ST_FORCE;
      pop     = 1'b1;
      addr_d  = fifo_addr[rd_ptr_q];
      din_d   = fifo_data[rd_ptr_q];
      we_d    = 1'b1;
      miss_d  = bus.iReadReq;
    end else
`endif
    if (bus.iReadReq) begin
      state_d = ST_READ;
      addr_d  = bus.iReadAddress;
    end else if (count_q != '0) begin
      state_d = ST_WRITE;
      pop     = 1'b1;
      addr_d  = fifo_addr[rd_ptr_q];
      din_d   = fifo_data[rd_ptr_q];
      we_d    = 1'b1;
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    // Full tracks the post-edge count so a refused push can never overflow.
    full_d = (count_d == CW'(DEPTH));
    rv_d   = (state_q == ST_READ);

`ifdef VRAM_STARVE_GUARD_EN
    stall_d = stall_q;
    if ((count_q == '0) || pop) begin
      stall_d = '0;
    end else if ((state_d == ST_READ) && (stall_q != SW'(MAX_STALL))) begin
      stall_d = stall_q + SW'(1);
    end
`endif
  end

  // Queue storage carries no reset; validity is owned by count and the pointers.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= bus.iWriteAddress;
      fifo_data[wr_ptr_q] <= bus.iWriteData;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      rv_q     <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      rv_q     <= rv_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      din_q    <= din_d;
    end
  end

`ifdef VRAM_STARVE_GUARD_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stall_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.oReadMiss = miss_q;
  assign dbg_stall     = stall_q;
`else
  assign bus.oReadMiss = 1'b0;
  assign dbg_stall     = '0;
`endif

  assign bus.oFull           = full_q;
  assign bus.oReadValid      = rv_q;
  assign bus.oRamAddress     = addr_q;
  assign bus.oRamWriteEnable = we_q;
  assign bus.oRamDataIn      = din_q;
  assign dbg_state           = state_q;
  assign dbg_count           = count_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler with a behavioural 1-cycle-latency RAM.
module tb_vram_write_scheduler;

  localparam int AW = 24;
  localparam int DW = 3;
  localparam int DEPTH = 8;

  logic       Clock;
  logic       Reset;
  logic [1:0] dbg_state;
  logic [3:0] dbg_count;
  logic [2:0] dbg_stall;

  int checks = 0;
  int failures = 0;

  vram_write_scheduler_if #(.AW(AW), .DW(DW)) bus_if ();

  vram_write_scheduler #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .MAX_STALL(4)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus_if.slave),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count),
    .dbg_stall (dbg_stall)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM model: location 0x20 powers up holding 5, everything else 0.
  logic [DW-1:0] mem [256];
  logic [255:0]  written = '0;
  always @(posedge Clock) begin
    if (bus_if.oRamWriteEnable) begin
      mem[bus_if.oRamAddress[7:0]]     <= bus_if.oRamDataIn;
      written[bus_if.oRamAddress[7:0]] <= 1'b1;
    end
    if (written[bus_if.oRamAddress[7:0]])
      bus_if.iRamDataOut <= mem[bus_if.oRamAddress[7:0]];
    else
      bus_if.iRamDataOut <= (bus_if.oRamAddress[7:0] == 8'h20) ? 3'd5 : 3'd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_write(input logic req, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.iWriteReq     = req;
    bus_if.iWriteAddress = a;
    bus_if.iWriteData    = d;
  endtask

  task automatic drive_read(input logic req, input logic [AW-1:0] a);
    bus_if.iReadReq     = req;
    bus_if.iReadAddress = a;
  endtask

  function automatic logic [31:0] out_vec();
    return {1'b0, bus_if.oFull, bus_if.oReadValid, bus_if.oReadMiss,
            bus_if.oRamWriteEnable, bus_if.oRamAddress, bus_if.oRamDataIn};
  endfunction

  function automatic logic [31:0] wr_vec(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {4'd0, we, a, d};
  endfunction

  function automatic logic [31:0] obs_wr();
    return wr_vec(bus_if.oRamWriteEnable, bus_if.oRamAddress, bus_if.oRamDataIn);
  endfunction

  logic [AW-1:0] t2_addr [3];
  logic [DW-1:0] t2_data [3];

  initial begin
    t2_addr = '{24'h10, 24'h11, 24'h12};
    t2_data = '{3'd1, 3'd2, 3'd3};
    Reset = 1'b0;
    drive_write(1'b0, '0, '0);
    drive_read(1'b0, '0);

    // Reset state
    #1;
    check("in_reset_outputs", out_vec(), 32'd0);
    check("in_reset_state", {30'd0, dbg_state}, 32'd0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_outputs", out_vec(), 32'd0);
    end
    check("idle_count", {28'd0, dbg_count}, 32'd0);

    // Three writes, no reads
    for (int i = 0; i < 3; i++) begin
      drive_write(1'b1, t2_addr[i], t2_data[i]);
      step();
      if (i > 0) check("wr3_drain", obs_wr(), wr_vec(1'b1, t2_addr[i-1], t2_data[i-1]));
    end
    drive_write(1'b0, '0, '0);
    step();
    check("wr3_drain_last", obs_wr(), wr_vec(1'b1, 24'h12, 3'd3));
    step();
    check("wr3_idle_hold", obs_wr(), wr_vec(1'b0, 24'h12, 3'd3));
    check("wr3_idle_state", {30'd0, dbg_state}, 32'd0);

`ifndef VRAM_STARVE_GUARD_EN
    // Nine writes under continuous reads: eight accepted, ninth held
    drive_read(1'b1, 24'h40);
    for (int i = 0; i < 9; i++) begin
      drive_write(1'b1, 24'h30 + AW'(i), DW'(i));
      step();
      check("fill_full", {31'd0, bus_if.oFull}, (i >= 7) ? 32'd1 : 32'd0);
      check("fill_no_we", {31'd0, bus_if.oRamWriteEnable}, 32'd0);
      if (i == 1) check("fill_read_valid", {31'd0, bus_if.oReadValid}, 32'd1);
    end
    check("fill_count", {28'd0, dbg_count}, 32'd8);
    drive_write(1'b0, '0, '0);
    drive_read(1'b0, '0);
    for (int j = 0; j < 8; j++) begin
      step();
      check("drain_order", obs_wr(), wr_vec(1'b1, 24'h30 + AW'(j), DW'(j)));
      if (j == 0) check("drain_full_clear", {31'd0, bus_if.oFull}, 32'd0);
    end
    step();
    check("drain_done_we", {31'd0, bus_if.oRamWriteEnable}, 32'd0);
    check("drain_done_count", {28'd0, dbg_count}, 32'd0);
`endif

    // Read 0x20 (preloaded 5) while a write to 0x20 is queued: no forwarding
    drive_read(1'b1, 24'h20);
    drive_write(1'b1, 24'h20, 3'd6);
    step();
    check("rd_addr", obs_wr(), wr_vec(1'b0, 24'h20, 3'd0) | {4'd0, 1'b0, 24'd0, bus_if.oRamDataIn});
    check("rd_addr_only", {8'd0, bus_if.oRamAddress}, 32'h20);
    check("rd_not_yet_valid", {31'd0, bus_if.oReadValid}, 32'd0);
    drive_read(1'b0, '0);
    drive_write(1'b0, '0, '0);
    step();
    check("rd_valid", {31'd0, bus_if.oReadValid}, 32'd1);
    check("rd_old_data", {29'd0, bus_if.iRamDataOut}, 32'd5);
    check("rd_then_write", obs_wr(), wr_vec(1'b1, 24'h20, 3'd6));
    drive_read(1'b1, 24'h20);
    step();
    check("rd2_valid_low", {31'd0, bus_if.oReadValid}, 32'd0);
    drive_read(1'b0, '0);
    step();
    check("rd2_valid", {31'd0, bus_if.oReadValid}, 32'd1);
    check("rd2_new_data", {29'd0, bus_if.iRamDataOut}, 32'd6);

`ifdef VRAM_STARVE_GUARD_EN
    // Starvation guard with MAX_STALL=4
    drive_read(1'b1, 24'h44);
    drive_write(1'b1, 24'h60, 3'd7);
    step();
    drive_write(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("guard_read_state", {30'd0, dbg_state}, 32'd1);
      check("guard_read_no_we", {31'd0, bus_if.oRamWriteEnable}, 32'd0);
    end
    step();
    check("guard_force_state", {30'd0, dbg_state}, 32'd3);
    check("guard_force_wr", obs_wr(), wr_vec(1'b1, 24'h60, 3'd7));
    check("guard_force_miss", {31'd0, bus_if.oReadMiss}, 32'd1);
    step();
    check("guard_resume_state", {30'd0, dbg_state}, 32'd1);
    check("guard_resume_miss", {31'd0, bus_if.oReadMiss}, 32'd0);
    drive_read(1'b0, '0);
    step();
    step();
`endif

    // Reset asserted mid-drain with five entries queued
    drive_read(1'b1, 24'h48);
    for (int i = 0; i < 5; i++) begin
      drive_write(1'b1, 24'h50 + AW'(i), DW'(i + 1));
      step();
    end
    drive_write(1'b0, '0, '0);
    drive_read(1'b0, '0);
    check("rst_pre_count", {28'd0, dbg_count}, 32'd5);
    step();
    check("rst_drain_started", {31'd0, bus_if.oRamWriteEnable}, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("rst_async_outputs", out_vec(), 32'd0);
    check("rst_async_count", {28'd0, dbg_count}, 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_after_no_we", {31'd0, bus_if.oRamWriteEnable}, 32'd0);
    end
    check("rst_after_count", {28'd0, dbg_count}, 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
